outlier_mask_accum: RTL and testbench

OUTLIER_MASK_ACCUM -- requirements
Module: outlier_mask_accum

---
 rtl/outlier_mask_accum.sv | 96 +++++++++
 tb/tb_outlier_mask_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/outlier_mask_accum.sv
// Sticky per-column outlier mask accumulator over NUM_ROWS beats per tensor.
// Optional OUTLIER_MASK_ACCUM_COUNT_EN adds a registered popcount of mask_out.
module outlier_mask_accum #(
    parameter int IN_SIZE  = 4,
    parameter int NUM_ROWS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_SIZE-1:0] data_in,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    output logic [IN_SIZE-1:0] mask_out,
    output logic               mask_out_valid,
    input  logic               mask_out_ready
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
    ,
    output logic [$clog2(IN_SIZE+1)-1:0] outlier_count
`endif
);

    localparam int CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROWS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IN_SIZE-1:0] mask;
    logic [IN_SIZE-1:0] mask_next;
    logic               in_hs;

    assign in_hs     = data_in_valid & data_in_ready;
    assign mask_next = mask | data_in;

`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
    localparam int OC_W = $clog2(IN_SIZE + 1);

    function automatic logic [OC_W-1:0] popcnt(input logic [IN_SIZE-1:0] v);
        logic [OC_W-1:0] s;
        s = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            s = s + OC_W'(v[i]);
        end
        return s;
    endfunction
`endif

    // data_in_ready is registered low in reset so it only rises on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ACCUM;
            cnt            <= '0;
            mask           <= '0;
            mask_out       <= '0;
            mask_out_valid <= 1'b0;
            data_in_ready  <= 1'b0;
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
            outlier_count  <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    data_in_ready <= 1'b1;
                    if (in_hs) begin
                        if (cnt == LAST) begin
                            mask_out       <= mask_next;
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
                            outlier_count  <= popcnt(mask_next);
`endif
                            mask           <= '0;
                            cnt            <= '0;
                            mask_out_valid <= 1'b1;
                            data_in_ready  <= 1'b0;
                            state          <= HOLD;
                        end else begin
                            mask <= mask_next;
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (mask_out_ready) begin
                        mask           <= '0;
                        mask_out_valid <= 1'b0;
                        data_in_ready  <= 1'b1;
                        state          <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outlier_mask_accum.sv
// Directed self-checking bench for outlier_mask_accum (NUM_ROWS=8 and NUM_ROWS=1 instances).
module tb_outlier_mask_accum;

    logic       clk;
    logic       rst_n;
    logic [3:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] a_mask;
    logic       a_mvalid;
    logic       a_mready;
    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_mask;
    logic       b_mvalid;
    logic       b_mready;
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
    logic [2:0] a_cnt;
    logic [2:0] b_cnt;
`endif

    int errors = 0;
    int checks = 0;

    outlier_mask_accum #(.IN_SIZE(4), .NUM_ROWS(8)) dut_a (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(a_data),
        .data_in_valid(a_valid),
        .data_in_ready(a_ready),
        .mask_out(a_mask),
        .mask_out_valid(a_mvalid),
        .mask_out_ready(a_mready)
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
        ,
        .outlier_count(a_cnt)
`endif
    );

    outlier_mask_accum #(.IN_SIZE(4), .NUM_ROWS(1)) dut_b (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(b_data),
        .data_in_valid(b_valid),
        .data_in_ready(b_ready),
        .mask_out(b_mask),
        .mask_out_valid(b_mvalid),
        .mask_out_ready(b_mready)
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
        ,
        .outlier_count(b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] sticky [8];
    int         gaps   [8];

    initial begin
        sticky = '{4'b0001, 4'b0000, 4'b0100, 4'b0000,
                   4'b0000, 4'b0000, 4'b0000, 4'b1000};
        gaps   = '{1, 0, 2, 0, 3, 1, 0, 2};
        rst_n    = 1'b0;
        a_data   = '0;
        a_valid  = 1'b0;
        a_mready = 1'b0;
        b_data   = '0;
        b_valid  = 1'b0;
        b_mready = 1'b0;
        tick();
        tick();
        chk("rst_ready", a_ready, 0);
        chk("rst_mvalid", a_mvalid, 0);
        chk("rst_mask", a_mask, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", a_ready, 1);

        // reset in the middle of a tensor
        a_data  = 4'b0001;
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        a_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("midrst_ready", a_ready, 0);
        chk("midrst_mvalid", a_mvalid, 0);
        chk("midrst_mask", a_mask, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_rel_ready", a_ready, 1);
        a_data  = 4'b0000;
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7) chk($sformatf("zero_row%0d_mvalid", i), a_mvalid, 0);
        end
        a_valid = 1'b0;
        chk("zero_mvalid", a_mvalid, 1);
        chk("zero_mask", a_mask, 4'b0000);
        chk("zero_hold_ready", a_ready, 0);
        a_mready = 1'b1;
        tick();
        chk("zero_drain_mvalid", a_mvalid, 0);
        chk("zero_drain_ready", a_ready, 1);
        a_mready = 1'b0;

        // sticky OR across rows
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data = sticky[i];
            tick();
        end
        a_valid = 1'b0;
        chk("sticky_mvalid", a_mvalid, 1);
        chk("sticky_mask", a_mask, 4'b1101);
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
        chk("sticky_count", a_cnt, 3);
`endif

        // backpressure while upstream keeps offering 1111
        a_data  = 4'b1111;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d_ready", i), a_ready, 0);
            chk($sformatf("bp%0d_mask", i), a_mask, 4'b1101);
            chk($sformatf("bp%0d_mvalid", i), a_mvalid, 1);
        end
        a_mready = 1'b1;
        tick();
        chk("bp_drain_mvalid", a_mvalid, 0);
        chk("bp_drain_ready", a_ready, 1);
        a_data = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
        a_valid = 1'b0;
        chk("bp_next_mvalid", a_mvalid, 1);
        chk("bp_next_mask", a_mask, 4'b0000);
        tick();

        // bubbles carrying 1111 on invalid cycles
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                a_valid = 1'b0;
                a_data  = 4'b1111;
                tick();
                chk("bub_gap_mvalid", a_mvalid, 0);
            end
            a_valid = 1'b1;
            a_data  = (i == 2) ? 4'b0010 : ((i == 5) ? 4'b0100 : 4'b0000);
            tick();
        end
        a_valid = 1'b0;
        chk("bub_mvalid", a_mvalid, 1);
        chk("bub_mask", a_mask, 4'b0110);
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
        chk("bub_count", a_cnt, 2);
`endif
        tick();
        chk("bub_drain_mvalid", a_mvalid, 0);

        // NUM_ROWS=1 instance
        b_mready = 1'b1;
        chk("b_idle_ready", b_ready, 1);
        b_data  = 4'b0010;
        b_valid = 1'b1;
        tick();
        chk("b1_mvalid", b_mvalid, 1);
        chk("b1_mask", b_mask, 4'b0010);
        chk("b1_ready", b_ready, 0);
        b_data = 4'b0100;
        tick();
        chk("b_gap_mvalid", b_mvalid, 0);
        chk("b_gap_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        chk("b2_mvalid", b_mvalid, 1);
        chk("b2_mask", b_mask, 4'b0100);
`ifdef OUTLIER_MASK_ACCUM_COUNT_EN
        chk("b2_count", b_cnt, 1);
`endif
        tick();
        chk("b_end_mvalid", b_mvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
